// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl_pkg: shared state encoding and default sizing for the clock-divider controller.
package clk_div_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  localparam int CNT_W_DFLT        = 8;
  localparam int DEFAULT_HALF_DFLT = 4;
endpackage

// File: rtl/clk_div_ctrl_div_core.sv
// div_core: half-period counter and output toggle; rises can be suppressed to end a run on a low level.
module div_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] i_half,
  input  logic             i_run,
  input  logic             i_suppress_rise,
  output logic             o_clk_out,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_boundary
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk, r_rise, r_fall;
  logic             w_bnd, w_tog;
  // >= rather than == so a half-period shrinking mid-phase cannot run the counter past its limit
  assign w_bnd = i_run & (r_cnt >= i_half - CNT_W'(1));
  assign w_tog = w_bnd & (r_clk | ~i_suppress_rise);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= (!i_run || w_bnd) ? '0 : r_cnt + CNT_W'(1);
      r_clk  <= i_run & (r_clk ^ w_tog);
      r_rise <= w_tog & ~r_clk;
      r_fall <= w_tog & r_clk;
    end
  assign o_clk_out  = r_clk;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_boundary = w_bnd;
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop sequencing and glitch-free half-period reconfiguration of a divided clock.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DFLT,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DFLT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_half,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_clk_out,
  output logic             o_tick_rise,
  output logic             o_tick_fall,
  output logic             o_running,
  output logic [CNT_W-1:0] o_cur_half
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cur_half, r_pend;
  logic             r_pend_vld, r_fresh, r_running, r_cfg_ready, r_cfg_err;
  logic             w_run, w_sup, w_bnd, w_clk, w_stop_end, w_xfer, w_apply;
  assign w_run      = r_state != IDLE;
  assign w_sup      = (r_state == STOPPING) & ~i_en;
  assign w_stop_end = w_bnd & w_sup;
  assign w_xfer     = i_cfg_valid & r_cfg_ready;
  // apply while idle, in the first run cycle if no toggle is due, or at a fall / stop boundary
  assign w_apply    = r_pend_vld & (~w_run | (r_fresh & ~w_bnd) | (w_bnd & (w_clk | w_sup)));
  assign w_next     = !w_run ? (i_en ? RUN : IDLE) : i_en ? RUN : w_stop_end ? IDLE : STOPPING;
  div_core #(.CNT_W(CNT_W)) u_core (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_half         (r_cur_half),
    .i_run          (w_run),
    .i_suppress_rise(w_sup),
    .o_clk_out      (w_clk),
    .o_rise         (o_tick_rise),
    .o_fall         (o_tick_fall),
    .o_boundary     (w_bnd)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state     <= IDLE;
      r_running   <= 1'b0;
      r_fresh     <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend      <= '0;
      r_cur_half  <= CNT_W'(DEFAULT_HALF);
    end else begin
      r_state   <= w_next;
      r_running <= w_next != IDLE;
      r_fresh   <= ~w_run & i_en;
      r_cfg_err <= w_xfer & ~|i_cfg_half;
      if (w_xfer && |i_cfg_half) begin
        r_pend      <= i_cfg_half;
        r_pend_vld  <= 1'b1;
        r_cfg_ready <= 1'b0;
      end else if (w_apply) begin
        r_cur_half  <= r_pend;
        r_pend_vld  <= 1'b0;
        r_cfg_ready <= 1'b1;
      end
    end
  assign o_clk_out   = w_clk;
  assign o_running   = r_running;
  assign o_cfg_ready = r_cfg_ready;
  assign o_cfg_err   = r_cfg_err;
  assign o_cur_half  = r_cur_half;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed checks of start/stop, reconfiguration and reset of clk_div_ctrl.
module tb_clk_div_ctrl;
  logic       clk = 1'b0, reset_n = 1'b0, en = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_half = 8'd0;
  logic       cfg_ready, cfg_err, clk_out, tick_rise, tick_fall, running;
  logic [7:0] cur_half;
  int         checks = 0, errors = 0, n;

  clk_div_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (en),
    .i_cfg_valid(cfg_valid),
    .i_cfg_half (cfg_half),
    .o_cfg_ready(cfg_ready),
    .o_cfg_err  (cfg_err),
    .o_clk_out  (clk_out),
    .o_tick_rise(tick_rise),
    .o_tick_fall(tick_fall),
    .o_running  (running),
    .o_cur_half (cur_half)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_lvl(input logic v, output int cnt);
    cnt = 0;
    while (clk_out !== v && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_clk"}, 32'(clk_out), 0);
    check({tag, "_run"}, 32'(running), 0);
    check({tag, "_rdy"}, 32'(cfg_ready), 1);
    check({tag, "_err"}, 32'(cfg_err), 0);
    check({tag, "_rise"}, 32'(tick_rise), 0);
    check({tag, "_fall"}, 32'(tick_fall), 0);
    check({tag, "_half"}, 32'(cur_half), 4);
  endtask

  initial begin
    step(3);
    check_reset_outs("rst");
    reset_n = 1'b1;
    step(1);
    // start with H=4: 4 cycles to first rise, then 4/4 duty
    en = 1'b1;
    step(1);
    check("start_run", 32'(running), 1);
    check("start_clk", 32'(clk_out), 0);
    wait_lvl(1'b1, n); check("first_rise", n, 4);
    check("rise_tick", 32'(tick_rise), 1);
    step(1);
    check("rise_tick_w", 32'(tick_rise), 0);
    wait_lvl(1'b0, n); check("high4", n + 1, 4);
    check("fall_tick", 32'(tick_fall), 1);
    wait_lvl(1'b1, n); check("low4", n, 4);
    // H=2 offered at the start of a high phase; applies at the fall
    cfg_valid = 1'b1; cfg_half = 8'd2;
    step(1);
    cfg_valid = 1'b0;
    check("cfg2_rdy_lo", 32'(cfg_ready), 0);
    wait_lvl(1'b0, n); check("cfg2_fall", n, 3);
    check("cfg2_half", 32'(cur_half), 2);
    check("cfg2_rdy_hi", 32'(cfg_ready), 1);
    wait_lvl(1'b1, n); check("low2", n, 2);
    wait_lvl(1'b0, n); check("high2", n, 2);
    wait_lvl(1'b1, n); check("low2b", n, 2);
    // back to H=4
    cfg_valid = 1'b1; cfg_half = 8'd4;
    step(1);
    cfg_valid = 1'b0;
    check("cfg4_rdy_lo", 32'(cfg_ready), 0);
    wait_lvl(1'b0, n); check("cfg4_fall", n, 1);
    check("cfg4_half", 32'(cur_half), 4);
    wait_lvl(1'b1, n); check("low_new4", n, 4);
    // stop requested in the high phase
    en = 1'b0;
    step(1);
    check("stop_hi_run", 32'(running), 1);
    wait_lvl(1'b0, n); check("stop_hi_fall", n, 3);
    check("stop_hi_idle", 32'(running), 0);
    step(6);
    check("idle_lo", 32'(clk_out), 0);
    // stop requested in the low phase: rise suppressed
    en = 1'b1;
    step(1);
    wait_lvl(1'b1, n); check("rs_rise", n, 4);
    wait_lvl(1'b0, n); check("rs_high", n, 4);
    en = 1'b0;
    step(3);
    check("stop_lo_run", 32'(running), 1);
    step(1);
    check("stop_lo_idle", 32'(running), 0);
    check("stop_lo_clk", 32'(clk_out), 0);
    check("stop_lo_norise", 32'(tick_rise), 0);
    step(4);
    check("stop_lo_hold", 32'(clk_out), 0);
    // stop then resume inside STOPPING: waveform undisturbed
    en = 1'b1;
    step(1);
    wait_lvl(1'b1, n); check("rz_rise", n, 4);
    en = 1'b0;
    step(1);
    en = 1'b1;
    wait_lvl(1'b0, n); check("resume_fall", n, 3);
    check("resume_run", 32'(running), 1);
    wait_lvl(1'b1, n); check("resume_low", n, 4);
    wait_lvl(1'b0, n); check("resume_high", n, 4);
    en = 1'b0;
    step(4);
    check("resume_idle", 32'(running), 0);
    // H=0 rejected in IDLE
    cfg_valid = 1'b1; cfg_half = 8'd0;
    step(1);
    cfg_valid = 1'b0;
    check("zero_err", 32'(cfg_err), 1);
    check("zero_rdy", 32'(cfg_ready), 1);
    check("zero_half", 32'(cur_half), 4);
    step(1);
    check("zero_err_w", 32'(cfg_err), 0);
    // H=1 offered together with en: applied on the next edge
    cfg_valid = 1'b1; cfg_half = 8'd1; en = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    check("h1_run", 32'(running), 1);
    check("h1_rdy_lo", 32'(cfg_ready), 0);
    step(1);
    check("h1_half", 32'(cur_half), 1);
    check("h1_rdy_hi", 32'(cfg_ready), 1);
    check("h1_clk0", 32'(clk_out), 0);
    step(1);
    check("h1_clk1", 32'(clk_out), 1);
    check("h1_rise1", 32'(tick_rise), 1);
    step(1);
    check("h1_clk2", 32'(clk_out), 0);
    check("h1_fall2", 32'(tick_fall), 1);
    check("h1_rise2", 32'(tick_rise), 0);
    step(1);
    check("h1_clk3", 32'(clk_out), 1);
    check("h1_rise3", 32'(tick_rise), 1);
    check("h1_fall3", 32'(tick_fall), 0);
    // async reset with a config pending
    cfg_valid = 1'b1; cfg_half = 8'd6;
    @(posedge clk);
    #1 check("pend_rdy", 32'(cfg_ready), 0);
    #1 reset_n = 1'b0;
    #1 check_reset_outs("arst");
    cfg_valid = 1'b0; en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(2);
    en = 1'b1;
    step(1);
    check("post_run", 32'(running), 1);
    wait_lvl(1'b1, n); check("post_rise", n, 4);
    wait_lvl(1'b0, n); check("post_high", n, 4);
    check("post_half", 32'(cur_half), 4);
    check("post_rdy", 32'(cfg_ready), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable clock-divider controller for the system-clock domain. It sequences a shared divided clock: start and stop on request, and changes the divide ratio through a valid/ready configuration port. Ratio changes are applied only at period boundaries, so downstream Braille timing logic never sees a runt or truncated pulse. It outputs the divided clock level plus single-cycle rise/fall enables for logic that stays on `clk`.

## Interface
- CNT_W, 8: width of half-period counter and config value.
- DEFAULT_HALF, 4: half-period (in `clk` cycles) loaded at reset; must be ≥1.
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  level run request; 1 = run divider, 0 = stop cleanly.
- cfg_valid  in  1  new half-period offered.
- cfg_half  in  CNT_W  requested half-period H (cycles per output level).
- cfg_ready  out  1  controller can accept a config.
- cfg_err  out  1  one-cycle pulse: accepted config had H=0, discarded.
- clk_out  out  1  divided clock, period 2·H, 50 % duty.
- tick_rise  out  1  one-cycle pulse in the first cycle clk_out reads 1.
- tick_fall  out  1  one-cycle pulse in the first cycle clk_out reads 0 after a high phase.
- running  out  1  1 in RUN or STOPPING.
- cur_half  out  CNT_W  half-period currently in force.

## Operation
- Reset values: state IDLE, cnt 0, clk_out 0, tick_rise 0, tick_fall 0, running 0, cfg_ready 1, cfg_err 0, cur_half DEFAULT_HALF, no pending config.
- States:
  - IDLE: clk_out held 0, cnt held 0. en=1 → RUN.
  - RUN: cnt counts 0..cur_half−1. At cnt==cur_half−1: toggle clk_out, cnt←0. en=0 → STOPPING.
  - STOPPING: keep counting.
    - If clk_out=1: at the falling boundary, toggle to 0 → IDLE.
    - If clk_out=0: at the end of the low half-period, suppress the rising toggle → IDLE.
    - en=1 while in STOPPING → RUN with no disturbance to cnt or clk_out.
- Every visible level lasts exactly cur_half cycles. After stopping, the low level lasts at least cur_half cycles.
- Config handshake: a transfer occurs when cfg_valid & cfg_ready are high on a clock edge.
  - H=0: cfg_err pulses the next cycle; no state change; cfg_ready stays 1.
  - H≥1: value is stored as pending and cfg_ready drops to 0 the next cycle.
- Applying a pending config:
  - In IDLE: cur_half←pending on the next edge.
  - In RUN or STOPPING: cur_half←pending on the same edge as the next 1→0 toggle (or the IDLE entry from STOPPING). The following low phase uses the new H.
  - cfg_ready returns to 1 on the cycle after apply.
- Simultaneous events:
  - Apply and stop on the same edge are both honoured.
  - A config transfer on the same edge as en rising from IDLE: the pending value is applied on the next edge, before the first toggle is possible when H≥2. When H=1 (current), apply waits for the first falling boundary.
- H=1: clk_out toggles every cycle (clk/2). tick_rise and tick_fall alternate every cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). Any pending config is lost.

## Timing
- All outputs are registered; no combinational path from input to output.
- en sampled 1 at edge k in IDLE → running=1 after edge k. clk_out first rises after edge k+H.
- tick_rise and tick_fall are asserted on the same edge that changes clk_out.
- Config accept to cfg_ready high: 2 cycles in IDLE. In RUN, this stretches until the next falling boundary + 1, at most 2·H+1 cycles.
- cur_half changes only on apply edges.

## Structure
- Package `clk_div_ctrl_pkg`: state enum {IDLE, RUN, STOPPING}, default CNT_W, default DEFAULT_HALF.
- Single module.
  - Optional sub-module `div_core`: counter + toggle, with inputs half, run, suppress_rise and outputs clk_out, rise, fall, boundary.
  - The FSM and config logic stay in clk_div_ctrl.

## Test plan
- Reset, en=1, H=4: running=1 one cycle later. clk_out period 8, duty 4/4. tick_rise/tick_fall each one cycle wide, coincident with edges.
- In RUN with H=4, offer cfg_half=2 mid high phase: cfg_ready low until the next fall. The following low phase is 2 cycles, then the period is 4. cur_half=2 from the apply edge.
- en→0 during the high phase, and separately during the low phase (H=4): no level shorter than 4 cycles. IDLE with clk_out=0. running drops on IDLE entry.
- en drops then re-rises in STOPPING: clk_out waveform identical to uninterrupted running.
- cfg_half=0 offered in IDLE: cfg_err single pulse, cur_half unchanged, cfg_ready stays 1. Then cfg_half=1 with en=1: clk_out toggles every cycle.
- reset_n pulsed low asynchronously mid-RUN with a config pending: outputs immediately at reset values. cur_half=4. The pending value is never applied.
